vga_timing_gen: RTL and testbench

//  Produces the VGA raster: pixel coordinates x/y consumed by all sprite/background/ROM readers,

---
 rtl/vga_pkg.sv | 31 +++
 rtl/sync_delay_line.sv | 49 ++++
 rtl/vga_timing_gen.sv | 142 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
//   Shared raster definitions for everything that consumes VGA coordinates
//   (background, pipes, bird and score readers, and the timing generator).
//   Holds the 640x480@60 default timing, the derived line/frame totals and
//   the coordinate types sized to hold those totals.
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int unsigned X_W = 11;
  localparam int unsigned Y_W = 10;

  typedef logic [X_W-1:0] coord_x_t;
  typedef logic [Y_W-1:0] coord_y_t;

  // 640x480@60 Hz default horizontal timing, in pixels.
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;

  // Default vertical timing, in lines.
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 800
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525

endpackage : vga_pkg

// File: rtl/sync_delay_line.sv
// ---------------------------------------------------------------------------
// sync_delay_line
//   DEPTH-stage shift register that delays a W-bit bundle by DEPTH enabled
//   clocks. DEPTH == 0 is a plain wire.
// Ports
//   clk      in   1   clock, posedge
//   rst_n    in   1   synchronous active-low reset; loads rst_val into every stage
//   en       in   1   shift enable; 0 holds every stage
//   rst_val  in   W   value every stage takes on reset
//   d        in   W   input bundle
//   q        out  W   input bundle delayed by DEPTH enabled clocks
// ---------------------------------------------------------------------------
module sync_delay_line #(
  parameter int unsigned W     = 3,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] rst_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    assign q = d;

    // Clock, reset and enable have no function in the pass-through case.
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, clk, rst_n, en, rst_val};
  end else begin : g_pipe
    logic [W-1:0] stage [DEPTH];

    // NOTE: every stage is reset, not just the last one; otherwise stale
    // sync/blank values already in flight would reach the output after a
    // mid-frame reset and show up as a partial pulse.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(DEPTH); i++) stage[i] <= rst_val;
      end else if (en) begin
        stage[0] <= d;
        for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule : sync_delay_line

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   VGA raster generator. x/y are the live, undelayed pixel coordinates so
//   ROM readers can issue addresses early; hsync/vsync/video_on are delayed
//   by SYNC_DELAY clocks so they line up with ROM-latency-delayed RGB.
// Ports
//   clk         in   1   system clock, posedge
//   rst_n       in   1   synchronous active-low reset
//   en          in   1   run enable; 0 freezes counters, divider and delay line
//   x           out  11  horizontal count 0..H_TOTAL-1
//   y           out  10  vertical count 0..V_TOTAL-1
//   pix_tick    out  1   x/y advance on this clock edge
//   line_tick   out  1   pix_tick on the last pixel of a line
//   frame_tick  out  1   pix_tick on the last pixel of a frame
//   hsync       out  1   horizontal sync, SYNC_POL level when active, delayed
//   vsync       out  1   vertical sync, SYNC_POL level when active, delayed
//   video_on    out  1   inside the visible area, delayed
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP       = vga_pkg::H_FP,
  parameter int unsigned H_SYNC     = vga_pkg::H_SYNC,
  parameter int unsigned H_BP       = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP       = vga_pkg::V_FP,
  parameter int unsigned V_SYNC     = vga_pkg::V_SYNC,
  parameter int unsigned V_BP       = vga_pkg::V_BP,
  parameter int unsigned PIX_DIV    = 1,
  parameter int unsigned SYNC_DELAY = 2,
  parameter bit          SYNC_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        pix_tick,
  output logic        line_tick,
  output logic        frame_tick,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on
);

  import vga_pkg::*;

  localparam int unsigned H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  // Elaboration-time parameter sanity checks.
  if (H_TOT >= 2048) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL must be < 2048");
  end
  if (V_TOT >= 1024) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL must be < 1024");
  end
  if (PIX_DIV < 1) begin : g_bad_pix_div
    $error("vga_timing_gen: PIX_DIV must be >= 1");
  end
  if (SYNC_DELAY > 7) begin : g_bad_sync_delay
    $error("vga_timing_gen: SYNC_DELAY must be <= 7");
  end

  // -------------------------------------------------------------------------
  // Pixel divider and raster counters
  // -------------------------------------------------------------------------
  logic [DIV_W-1:0] div;
  logic             div_last;
  logic             x_last;
  logic             y_last;

  assign div_last = (div == DIV_W'(PIX_DIV - 1));
  assign x_last   = (x == coord_x_t'(H_TOT - 1));
  assign y_last   = (y == coord_y_t'(V_TOT - 1));

  // Ticks are combinational so they coincide with the edge that moves x/y.
  // They are also held low while reset is asserted, since no advance happens
  // on that edge.
  assign pix_tick   = en & rst_n & div_last;
  assign line_tick  = pix_tick & x_last;
  assign frame_tick = line_tick & y_last;

  // NOTE: state registers use non-blocking assignments only, so every read
  // in this block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div <= '0;
      x   <= '0;
      y   <= '0;
    end else if (en) begin
      div <= div_last ? '0 : div + DIV_W'(1);
      if (div_last) begin
        if (x_last) begin
          x <= '0;
          y <= y_last ? '0 : y + coord_y_t'(1);
        end else begin
          x <= x + coord_x_t'(1);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Raw sync/blank decode from the registered coordinates (active-high)
  // -------------------------------------------------------------------------
  logic hs_raw;
  logic vs_raw;
  logic vo_raw;

  assign hs_raw = (x >= coord_x_t'(HS_START)) && (x < coord_x_t'(HS_END));
  assign vs_raw = (y >= coord_y_t'(VS_START)) && (y < coord_y_t'(VS_END));
  assign vo_raw = (x < coord_x_t'(H_ACTIVE)) && (y < coord_y_t'(V_ACTIVE));

  // -------------------------------------------------------------------------
  // Delay line: shifts every enabled clock (not per pixel) so the delay is
  // measured in clocks, matching ROM read latency. Resets to inactive/blank.
  // -------------------------------------------------------------------------
  logic [2:0] dly_q;

  sync_delay_line #(
    .W     (3),
    .DEPTH (SYNC_DELAY)
  ) u_sync_delay_line (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .rst_val (3'b000),
    .d       ({hs_raw, vs_raw, vo_raw}),
    .q       (dly_q)
  );

  // Polarity is applied after the delay so the pipeline stays active-high.
  assign hsync    = dly_q[2] ^ ~SYNC_POL;
  assign vsync    = dly_q[1] ^ ~SYNC_POL;
  assign video_on = dly_q[0];

endmodule : vga_timing_gen

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Four generator instances share clk/rst_n/en: the default 640x480 timing
//   with SYNC_DELAY=2, and three small rasters (17x10 totals) with
//   PIX_DIV 1/4/3, SYNC_DELAY 0/3/1 and both sync polarities so whole frames
//   fit in a short run. The reference model counts enabled clocks since
//   reset and derives every output from that count with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int NI = 4;

  localparam int P_HA [NI] = '{640, 10, 10, 10};
  localparam int P_HF [NI] = '{ 16,  2,  2,  2};
  localparam int P_HS [NI] = '{ 96,  3,  3,  3};
  localparam int P_HB [NI] = '{ 48,  2,  2,  2};
  localparam int P_VA [NI] = '{480,  5,  5,  5};
  localparam int P_VF [NI] = '{ 10,  1,  1,  1};
  localparam int P_VS [NI] = '{  2,  2,  2,  2};
  localparam int P_VB [NI] = '{ 33,  2,  2,  2};
  localparam int P_DV [NI] = '{  1,  1,  4,  3};
  localparam int P_SD [NI] = '{  2,  0,  3,  1};
  localparam int P_PO [NI] = '{  0,  0,  0,  1};

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  logic [10:0] xo  [NI];
  logic [9:0]  yo  [NI];
  logic        pt  [NI];
  logic        lt  [NI];
  logic        ft  [NI];
  logic        hs  [NI];
  logic        vs  [NI];
  logic        vo  [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    vga_timing_gen #(
      .H_ACTIVE   (P_HA[g]),
      .H_FP       (P_HF[g]),
      .H_SYNC     (P_HS[g]),
      .H_BP       (P_HB[g]),
      .V_ACTIVE   (P_VA[g]),
      .V_FP       (P_VF[g]),
      .V_SYNC     (P_VS[g]),
      .V_BP       (P_VB[g]),
      .PIX_DIV    (P_DV[g]),
      .SYNC_DELAY (P_SD[g]),
      .SYNC_POL   (P_PO[g] != 0)
    ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .x          (xo[g]),
      .y          (yo[g]),
      .pix_tick   (pt[g]),
      .line_tick  (lt[g]),
      .frame_tick (ft[g]),
      .hsync      (hs[g]),
      .vsync      (vs[g]),
      .video_on   (vo[g])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: n = number of enabled clocks since the last reset.
  // Pixel index p = n / PIX_DIV; x = p mod H_TOTAL; y = (p / H_TOTAL) mod V_TOTAL.
  // Delayed outputs equal the raw decode at count n - SYNC_DELAY, or the
  // inactive/blank level while fewer than SYNC_DELAY clocks have elapsed.
  // -------------------------------------------------------------------------
  longint n = 0;
  bit     model_valid = 1'b0;

  always @(posedge clk) begin
    if (rst_n === 1'b0) begin
      n           <= 0;
      model_valid <= 1'b1;
    end else if (en === 1'b1 && model_valid) begin
      n <= n + 1;
    end
  end

  function automatic logic [26:0] model_out(input int i, input longint cnt,
                                            input logic en_v, input logic rst_v);
    longint ht = P_HA[i] + P_HF[i] + P_HS[i] + P_HB[i];
    longint vt = P_VA[i] + P_VF[i] + P_VS[i] + P_VB[i];
    longint p  = cnt / P_DV[i];
    longint xx = p % ht;
    longint yy = (p / ht) % vt;
    logic   tp, tl, tf, h, v, o;
    tp = rst_v && en_v && ((cnt % P_DV[i]) == P_DV[i] - 1);
    tl = tp && (xx == ht - 1);
    tf = tl && (yy == vt - 1);
    h = 1'b0; v = 1'b0; o = 1'b0;
    if (cnt >= P_SD[i]) begin
      longint pm = (cnt - P_SD[i]) / P_DV[i];
      longint xm = pm % ht;
      longint ym = (pm / ht) % vt;
      h = (xm >= P_HA[i] + P_HF[i]) && (xm < P_HA[i] + P_HF[i] + P_HS[i]);
      v = (ym >= P_VA[i] + P_VF[i]) && (ym < P_VA[i] + P_VF[i] + P_VS[i]);
      o = (xm < P_HA[i]) && (ym < P_VA[i]);
    end
    if (P_PO[i] == 0) begin
      h = ~h;
      v = ~v;
    end
    return {11'(xx), 10'(yy), tp, tl, tf, h, v, o};
  endfunction

  // Single compare process: every instance, every cycle once reset was seen.
  always @(negedge clk) begin
    if (model_valid) begin
      for (int i = 0; i < NI; i++) begin
        check($sformatf("model_i%0d", i),
              64'({xo[i], yo[i], pt[i], lt[i], ft[i], hs[i], vs[i], vo[i]}),
              64'(model_out(i, n, en, rst_n)));
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus and hand-computed pins
  // -------------------------------------------------------------------------
  initial begin
    int hs_low_cnt;
    int first_low_x;
    int lt_x;
    int x_at_800;
    int y_at_800;
    int k;
    int held_bad;
    int tick_cnt;
    int ft_cnt;
    int pt_cnt;

    rst_n = 1'b0;
    en    = 1'b1;

    // Reset held for 5 clocks, then released.
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_x",        64'(xo[0]), 64'd0);
    check("reset_y",        64'(yo[0]), 64'd0);
    check("reset_hsync",    64'(hs[0]), 64'd1);
    check("reset_vsync",    64'(vs[0]), 64'd1);
    check("reset_video_on", 64'(vo[0]), 64'd0);
    check("reset_hsync_pol1", 64'(hs[3]), 64'd0);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("first_clk_x", 64'(xo[0]), 64'd1);
    check("video_on_pre_delay", 64'(vo[0]), 64'd0);
    @(negedge clk);
    check("video_on_rise_2clk", 64'(vo[0]), 64'd1);

    // One full line on the default timing (n runs 3..802).
    hs_low_cnt  = 0;
    first_low_x = -1;
    lt_x        = -1;
    x_at_800    = -1;
    y_at_800    = -1;
    k           = 2;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      k++;
      if (hs[0] == 1'b0) begin
        hs_low_cnt++;
        if (first_low_x < 0) first_low_x = int'(xo[0]);
      end
      if (lt[0] && lt_x < 0) lt_x = int'(xo[0]);
      if (k == 800) begin
        x_at_800 = int'(xo[0]);
        y_at_800 = int'(yo[0]);
      end
    end
    check("hsync_low_clks",     64'(hs_low_cnt),  64'd96);
    check("hsync_first_low_x",  64'(first_low_x), 64'd658);
    check("line_tick_x",        64'(lt_x),        64'd799);
    check("line_wrap_x",        64'(x_at_800),    64'd0);
    check("line_wrap_y",        64'(y_at_800),    64'd1);

    // Enable held low for 37 clocks at x=300.
    for (int c = 0; c < 2000 && xo[0] != 11'd300; c++) @(negedge clk);
    check("reach_x300", 64'(xo[0]), 64'd300);
    #1 en = 1'b0;
    held_bad = 0;
    tick_cnt = 0;
    repeat (37) begin
      @(negedge clk);
      if (xo[0] != 11'd300) held_bad++;
      if (pt[0] || lt[0] || ft[0]) tick_cnt++;
    end
    check("en_low_x_moved", 64'(held_bad), 64'd0);
    check("en_low_ticks",   64'(tick_cnt), 64'd0);
    #1 en = 1'b1;
    @(negedge clk);
    check("en_resume_x", 64'(xo[0]), 64'd301);

    // Reset asserted in the middle of an hsync pulse.
    for (int c = 0; c < 2000 && xo[0] != 11'd700; c++) @(negedge clk);
    check("reach_x700",      64'(xo[0]), 64'd700);
    check("hsync_active_700", 64'(hs[0]), 64'd0);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("midreset_x",     64'(xo[0]), 64'd0);
    check("midreset_y",     64'(yo[0]), 64'd0);
    check("midreset_hsync", 64'(hs[0]), 64'd1);
    #1 rst_n = 1'b1;

    // 510 clocks on the small rasters: 3 frames of 170 pixels at PIX_DIV=1,
    // and a 1-in-4 pixel strobe at PIX_DIV=4.
    ft_cnt = 0;
    pt_cnt = 0;
    repeat (510) begin
      @(negedge clk);
      if (ft[1]) ft_cnt++;
      if (pt[2]) pt_cnt++;
    end
    check("small_frame_ticks", 64'(ft_cnt), 64'd3);
    check("div4_pix_ticks",    64'(pt_cnt), 64'd127);

    // Randomised enable with rare resets; the model checks every cycle.
    repeat (20000) begin
      @(posedge clk);
      #1;
      en    = ($urandom_range(0, 9) < 8);
      rst_n = ($urandom_range(0, 2999) != 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_vga_timing_gen
